dbus_bridge: RTL
================

// Module: dbus_bridge
// PURPOSE
//  Data-bus bridge directly downstream of the memory-access stage. Takes the registered dbus_req_t
//  (valid held until data_ok) and runs one transaction on the on-chip memory port (valid/ready
//  request channel, rvalid response channel). Returns a single-cycle data_ok pulse with read data.
//  Adds alignment checking and a response watchdog so the pipeline can never hang on the data port.
// PARAMETERS
//  TIMEOUT_CYC   256   cycles waited for mem_rvalid after request acceptance before forced completion
//  CNT_W         9     watchdog counter width; must hold TIMEOUT_CYC
// PORTS
//  clk          in   1            clock, all state on posedge
//  rst          in   1            reset, asynchronous, active-low
//  dreq         in   dbus_req_t   request from memory stage: valid, addr[63:0], size[2:0], strobe[7:0], data[63:0]
//  dresp        out  dbus_resp_t  response: addr_ok, data_ok, data[63:0]
//  mem_valid    out  1            request valid on memory port
//  mem_ready    in   1            memory accepts request this cycle
//  mem_addr     out  64           byte address, passed through unmodified
//  mem_we       out  1            1 = write (strobe != 0), 0 = read
//  mem_strobe   out  8            byte enables, passed through (0 on reads)
//  mem_wdata    out  64           lane-aligned write data, passed through
//  mem_rvalid   in   1            read data / write ack valid
//  mem_rdata    in   64           raw 64-bit read beat (stage does lane extraction)
//  misalign_o   out  1            1-cycle pulse: request rejected, addr not aligned to 2^size
//  timeout_o    out  1            1-cycle pulse: watchdog fired
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; dresp.addr_ok/data_ok=0, dresp.data=0; mem_valid=0, mem_we=0,
//   mem_addr/strobe/wdata=0; misalign_o=timeout_o=0; watchdog=0. Reset mid-transaction abandons it;
//   late mem_rvalid after reset release is ignored in IDLE.
//  FSM: IDLE -> REQ -> WAIT -> RESP -> IDLE; IDLE -> RESP on misalign.
//  IDLE: on dreq.valid latch addr/size/strobe/data into holding regs; addr_ok=1 for this cycle.
//   Misaligned if addr[2:0] & ((1<<size)-1) != 0 (size 0..3) -> RESP with data=0, pulse misalign_o,
//   no memory access. Otherwise -> REQ.
//  REQ: mem_valid=1, fields from holding regs (stable while mem_valid && !mem_ready).
//   mem_valid && mem_ready -> WAIT, clear watchdog. mem_rvalid in REQ is ignored.
//  WAIT: mem_valid=0. mem_rvalid -> latch mem_rdata (writes: latch but value irrelevant) -> RESP.
//   Watchdog +1 per cycle; at TIMEOUT_CYC-1 with no rvalid -> RESP, data=64'hDEAD_BEEF_DEAD_BEEF,
//   pulse timeout_o. rvalid in the same cycle as expiry wins: real data, no timeout_o.
//  RESP: data_ok=1 exactly one cycle, dresp.data = latched value; -> IDLE. dreq.valid is still high in
//   this cycle (stage clears it on the data_ok edge); bridge must NOT re-accept it. IDLE accepts a new
//   request the cycle after RESP at earliest.
//  Latency, zero-wait memory (ready=1, rvalid the cycle after accept): dreq.valid seen cycle 0,
//   mem_valid cycle 1, rvalid cycle 2, data_ok cycle 3. Misaligned: data_ok cycle 1.
//  One outstanding transaction; dreq contents changing outside IDLE are ignored (holding regs used).
//  dresp.data holds its last value outside RESP; only the data_ok cycle is meaningful.
// TESTING
//  1 Read, zero-wait: addr=0x8000_0010,size=3,strobe=0; rvalid rdata=0x1122334455667788 ->
//    mem_valid cyc1, data_ok=1 cyc3 only, dresp.data=0x1122334455667788, mem_we=0.
//  2 Write w/ backpressure: addr=0x8000_0004,size=2,strobe=0xF0,data=0xAABBCCDD_00000000, mem_ready=0
//    for 3 cycles -> mem_valid held 4 cycles, fields stable, mem_we=1; data_ok 1 cycle after rvalid.
//  3 Misaligned: addr=0x8000_0003,size=1 -> no mem_valid ever, misalign_o + data_ok in cyc1, data=0.
//  4 Watchdog: TIMEOUT_CYC=8, accept, never rvalid -> timeout_o + data_ok with 0xDEADBEEFDEADBEEF
//    8 cycles after accept; repeat with rvalid on expiry cycle -> real data, timeout_o=0.
//  5 Back-to-back: dreq.valid held through data_ok then new read -> exactly 2 mem accesses, no
//    duplicate of first; second accepted no earlier than cycle after first data_ok.
//  6 Reset in WAIT: drop rst, release, then stray rvalid -> all outputs 0, state IDLE, no data_ok.

Source files
------------

// File: rtl/dbus_bridge.sv
// dbus_bridge: memory-stage data-bus bridge with alignment check and response watchdog
package dbus_pkg;
  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;
  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;
endpackage

module dbus_bridge import dbus_pkg::*; #(
  parameter int TIMEOUT_CYC = 256,
  parameter int CNT_W = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  dbus_req_t   dreq,
  output dbus_resp_t  dresp,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [63:0] mem_addr,
  output logic        mem_we,
  output logic [7:0]  mem_strobe,
  output logic [63:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [63:0] mem_rdata,
  output logic        misalign_o,
  output logic        timeout_o
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;
  state_e state_q, state_d;
  logic [63:0] addr_q, wdata_q, rdata_q, rdata_d;
  logic [7:0] strobe_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic mis_q, mis_d, to_q, to_d;
  logic misaligned, expire;
  assign misaligned = |(dreq.addr[2:0] & ~(3'h7 << dreq.size));
  assign expire = cnt_q == CNT_W'(TIMEOUT_CYC - 1);
  assign mem_valid = state_q == REQ;
  assign mem_addr = addr_q;
  assign mem_strobe = strobe_q;
  assign mem_wdata = wdata_q;
  assign mem_we = |strobe_q;
  assign misalign_o = mis_q;
  assign timeout_o = to_q;
  assign dresp.addr_ok = rst && state_q == IDLE && dreq.valid;
  assign dresp.data_ok = state_q == RESP;
  assign dresp.data = rdata_q;
  // Next-state: accept in IDLE, hand off in REQ, wait for data or watchdog in WAIT, one-cycle RESP
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    rdata_d = rdata_q;
    mis_d = 1'b0;
    to_d = 1'b0;
    case (state_q)
      IDLE: if (dreq.valid) begin
        state_d = misaligned ? RESP : REQ;
        rdata_d = misaligned ? '0 : rdata_q;
        mis_d = misaligned;
      end
      REQ: if (mem_ready) begin
        state_d = WAIT;
        cnt_d = '0;
      end
      WAIT: if (mem_rvalid) begin
        state_d = RESP;
        rdata_d = mem_rdata;
      end else if (expire) begin
        state_d = RESP;
        rdata_d = 64'hDEAD_BEEF_DEAD_BEEF;
        to_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  // State, watchdog, response data and completion-pulse registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      rdata_q <= '0;
      mis_q <= 1'b0;
      to_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rdata_q <= rdata_d;
      mis_q <= mis_d;
      to_q <= to_d;
    end
  end
  // Holding registers capture the request once so later dreq changes cannot disturb the memory port
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q <= '0;
      strobe_q <= '0;
      wdata_q <= '0;
    end else if (state_q == IDLE && dreq.valid) begin
      addr_q <= dreq.addr;
      strobe_q <= dreq.strobe;
      wdata_q <= dreq.data;
    end
  end
endmodule
